// File: rtl/mux_stim_checker.sv
// mux_stim_checker: serialises three words onto a 2:1 mux, captures and checks its output
//   clk, rst_n          : clock, async active-low reset
//   start               : run request, honoured in IDLE only
//   a_word/b_word       : channel-0/1 data words, bit i on step i
//   sel_word            : select pattern, bit i on step i
//   out                 : mux output fed back from the mux
//   a0/a1/sel           : mux stimulus bits
//   busy/done           : run in progress / one-cycle completion pulse
//   result/mismatch     : captured mux outputs / sticky error flag
module mux_stim_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  input  logic [WIDTH-1:0] sel_word,
  input  logic             out,
  output logic             a0,
  output logic             a1,
  output logic             sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mismatch
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb, ss;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // the unused encoding falls through to IDLE
  always_comb begin
    state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == CNT_W'(WIDTH-1) ? DONE : SHIFT) : IDLE;
  end
  // stimulus is gated by state so the mux sees zeros outside SHIFT
  always_comb begin
    busy = state == SHIFT;
    done = state == DONE;
    a0   = busy & sa[0];
    a1   = busy & sb[0];
    sel  = busy & ss[0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      ss       <= '0;
      cnt      <= '0;
      result   <= '0;
      mismatch <= 1'b0;
    end else if (state == IDLE && start) begin
      sa       <= a_word;
      sb       <= b_word;
      ss       <= sel_word;
      cnt      <= '0;
      result   <= '0;
      mismatch <= 1'b0;
    end else if (state == SHIFT) begin
      // result was cleared at start, so OR-ing places out at bit cnt
      result   <= result | (WIDTH'(out) << cnt);
      mismatch <= mismatch | (out != (ss[0] ? sb[0] : sa[0]));
      sa       <= sa >> 1;
      sb       <= sb >> 1;
      ss       <= ss >> 1;
      cnt      <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_mux_stim_checker.sv
// tb_mux_stim_checker: directed scoreboard bench for mux_stim_checker
module tb_mux_stim_checker;
  logic clk = 0, rst_n = 0, start = 0, out, flip = 0;
  logic [7:0] a_word = 0, b_word = 0, sel_word = 0, result;
  logic a0, a1, sel, busy, done, mismatch;
  logic [8:0] q[$];
  int checks = 0, errors = 0, cyc = 0, last_done = -1;
  bit hold = 0;
  mux_stim_checker #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_word(a_word), .b_word(b_word),
    .sel_word(sel_word), .out(out), .a0(a0), .a1(a1), .sel(sel), .busy(busy),
    .done(done), .result(result), .mismatch(mismatch)
  );
  assign out = (sel ? a1 : a0) ^ flip;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [8:0] model(input logic [7:0] a, b, s, input int fs);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) e[i] = (s[i] ? b[i] : a[i]) ^ (i == fs);
    return {e, fs < 8};
  endfunction
  always @(negedge clk)
    if (rst_n && done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        logic [8:0] e;
        e = q.pop_front();
        chk("result", result, e[8:1]);
        chk("mismatch", mismatch, e[0]);
      end
      if (hold && last_done >= 0) chk("done_gap", cyc - last_done, 10);
      last_done = cyc;
    end
  task automatic run(input logic [7:0] a, b, s, input int fs, input bit rs);
    q.push_back(model(a, b, s, fs));
    a_word = a; b_word = b; sel_word = s; start = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 8; i++) begin
      flip = (i == fs);
      if (rs && i == 2) begin start = 1; a_word = ~a; b_word = ~b; sel_word = ~s; end
      if (rs && i == 3) start = 0;
      chk("busy_step", busy, 1);
      chk("a0_step", a0, a[i]);
      chk("a1_step", a1, b[i]);
      chk("sel_step", sel, s[i]);
      @(posedge clk); #1;
    end
    flip = 0;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("stim_done", {a0, a1, sel}, 0);
    @(posedge clk); #1;
    chk("busy_idle", busy, 0);
    chk("done_idle", done, 0);
  endtask
  initial begin
    #2;
    chk("rst_stim", {a0, a1, sel, busy, done}, 0);
    chk("rst_result", {result, mismatch}, 0);
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    run(8'hF0, 8'h0F, 8'hFF, 8, 0);
    run(8'hF0, 8'h0F, 8'h00, 8, 0);
    run(8'h00, 8'hFF, 8'hAA, 8, 0);
    run(8'h55, 8'h55, 8'h0F, 3, 0);
    flip = 1;
    repeat (3) begin
      chk("mismatch_hold", mismatch, 1);
      chk("result_hold", result, 8'h5D);
      @(posedge clk); #1;
    end
    flip = 0;
    run(8'h3C, 8'hC3, 8'hF0, 8, 1);
    a_word = 8'hFF; b_word = 8'hFF; sel_word = 8'hFF; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_stim", {a0, a1, sel, busy}, 4'hF);
    rst_n = 0;
    #1;
    chk("async_rst_stim", {a0, a1, sel, busy}, 0);
    chk("async_rst_result", {result, mismatch}, 0);
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    run(8'hA5, 8'h5A, 8'h33, 8, 0);
    hold = 1; last_done = -1;
    for (int k = 0; k < 3; k++) q.push_back(model(8'hF0, 8'h0F, 8'hAA, 8));
    a_word = 8'hF0; b_word = 8'h0F; sel_word = 8'hAA; start = 1;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #1;
      chk("hold_busy", busy, (j % 10) < 8);
      chk("hold_done", done, (j % 10) == 8);
    end
    start = 0;
    repeat (3) @(posedge clk);
    #1;
    hold = 0;
    chk("hold_idle", busy, 0);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
